// File: rtl/ppu_vram_port.sv
// rtl/ppu_vram_port.sv - CPU PPUADDR/PPUDATA access port onto the shared VRAM bus.
// Optional PPU_PALETTE_BYPASS_EN: $2007 reads of $3Fxx return VRAM data unbuffered.
`timescale 1ns/1ps
module ppu_vram_port #(
  parameter int VRAM_AW = 14,
  parameter int INC_BIG = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_stb,
  input  logic [2:0]         cpu_sel,
  input  logic               cpu_rnw,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  output logic               cpu_busy,
  input  logic               inc32,
  input  logic               rnd_act,
  input  logic [VRAM_AW-1:0] rnd_addr,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_wr,
  output logic [7:0]         vram_dout,
  input  logic [7:0]         vram_din
);

  typedef enum logic [2:0] {IDLE, WAIT, WRITE, RADDR, RCAP} state_t;

  state_t             state, state_nxt;
  logic [VRAM_AW-1:0] v;
  logic [5:0]         t_hi;
  logic               toggle;
  logic [7:0]         rd_buf;
  logic               op_wr;
  logic               accept;
  logic               cpu_owns_bus;
  logic [VRAM_AW-1:0] inc;
`ifdef PPU_PALETTE_BYPASS_EN
  logic               pal_rd;
  logic               pal_addr;
  assign pal_addr = (v[VRAM_AW-1 -: 6] == 6'h3F);
`endif

  assign accept       = cpu_stb && (state == IDLE);
  assign cpu_owns_bus = (state == WRITE) || (state == RADDR);
  assign inc          = inc32 ? VRAM_AW'(INC_BIG) : VRAM_AW'(1);
  assign vram_addr    = cpu_owns_bus ? v : rnd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && cpu_sel == 3'd7) state_nxt = WAIT;
      WAIT:    if (!rnd_act) state_nxt = op_wr ? WRITE : RADDR;
      WRITE:   state_nxt = IDLE;
      RADDR:   state_nxt = RCAP;
      RCAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v         <= '0;
      t_hi      <= '0;
      toggle    <= 1'b0;
      rd_buf    <= '0;
      op_wr     <= 1'b0;
      cpu_dout  <= '0;
      cpu_busy  <= 1'b0;
      vram_wr   <= 1'b0;
      vram_dout <= '0;
`ifdef PPU_PALETTE_BYPASS_EN
      pal_rd    <= 1'b0;
`endif
    end else begin
      // Both flops mirror the next state so they line up exactly with it.
      cpu_busy <= (state_nxt != IDLE);
      vram_wr  <= (state_nxt == WRITE);
      if (accept) begin
        case (cpu_sel)
          3'd2: if (cpu_rnw) toggle <= 1'b0;
          3'd6: begin
            if (!cpu_rnw) begin
              if (!toggle) begin
                t_hi   <= cpu_din[5:0];
                toggle <= 1'b1;
              end else begin
                v      <= VRAM_AW'({t_hi, cpu_din});
                toggle <= 1'b0;
              end
            end
          end
          3'd7: begin
            op_wr <= !cpu_rnw;
            if (!cpu_rnw) begin
              vram_dout <= cpu_din;
            end else begin
`ifdef PPU_PALETTE_BYPASS_EN
              pal_rd <= pal_addr;
              if (!pal_addr) cpu_dout <= rd_buf;
`else
              cpu_dout <= rd_buf;
`endif
            end
          end
          default: ;
        endcase
      end
      if (cpu_owns_bus) v <= v + inc;
      if (state == RCAP) begin
        rd_buf <= vram_din;
`ifdef PPU_PALETTE_BYPASS_EN
        if (pal_rd) cpu_dout <= vram_din;
`endif
      end
    end
  end

endmodule

// File: doc/ppu_vram_port.md
Name: ppu_vram_port

Overview:
- CPU-facing VRAM access port of the PPU: implements the PPUADDR ($2006) two-write address latch and PPUDATA ($2007) buffered read/write, with 1/32 auto-increment.
- Sits directly upstream of the PPU memory controller. Drives its wr/addr/din and consumes its synchronous read data.
- Shares the VRAM bus with the background/sprite renderer; renderer has priority and CPU accesses are deferred.

Parameters:
- VRAM_AW, 14, VRAM address width; the increment wraps modulo 2^VRAM_AW.
- INC_BIG, 32, increment applied when inc32=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cpu_stb  in  1  single-cycle strobe for one CPU PPU-register access
- cpu_sel  in  3  register index (CPU addr[2:0])
- cpu_rnw  in  1  1=read, 0=write
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  $2007 read data, registered
- cpu_busy  out  1  port is processing an access; strobes are ignored while high
- inc32  in  1  PPUCTRL bit 2; 0: +1, 1: +INC_BIG
- rnd_act  in  1  renderer owns the VRAM bus
- rnd_addr  in  14  renderer VRAM address
- vram_addr  out  14  to memory controller addr
- vram_wr  out  1  to memory controller wr
- vram_dout  out  8  to memory controller din
- vram_din  in  8  memory controller dout; valid the cycle after the address is presented

Behaviour:
- Reset (async, rst_n=0): state=IDLE, v=0, t_hi=0, toggle=0, rd_buf=0, cpu_dout=0, vram_wr=0, vram_dout=0, cpu_busy=0.
- Registers: v[13:0] (current address), t_hi[5:0], toggle, rd_buf[7:0], op (rd/wr), state.
- Strobe decode in IDLE only:
  - sel=2 read: toggle<=0. This block drives no status data.
  - sel=6 write, toggle=0: t_hi<=cpu_din[5:0], toggle<=1. Bits [7:6] are dropped.
  - sel=6 write, toggle=1: v<={t_hi,cpu_din}, toggle<=0.
  - sel=7 write: vram_dout<=cpu_din, op=wr, go to WAIT.
  - sel=7 read: cpu_dout<=rd_buf on the next edge (returns the prior buffered byte), op=rd, go to WAIT.
  - All other sel values: no effect.
- Any strobe while state!=IDLE is dropped, with no side effects. cpu_busy = (state!=IDLE), registered.
- States:
  - WAIT: stay while rnd_act=1. When rnd_act=0, go to WRITE (op=wr) or RADDR (op=rd).
  - WRITE: vram_addr=v, vram_wr=1 for exactly one cycle; v<=v+inc; go to IDLE.
  - RADDR: vram_addr=v, vram_wr=0; v<=v+inc; go to RCAP.
  - RCAP: rd_buf<=vram_din; go to IDLE.
- Bus mux:
  - vram_addr = v in WRITE/RADDR, else rnd_addr.
  - vram_wr is asserted only in WRITE.
  - Renderer contract: rnd_act low windows are at least 2 cycles. The CPU owns exactly one cycle after rnd_act is seen low.
- Latency, no contention: $2007 write reaches vram_wr 2 cycles after cpu_stb. $2007 read refills rd_buf 3 cycles after cpu_stb.
- inc = inc32 ? INC_BIG : 1. v wraps modulo 2^14 (0x3FFF+1=0x0000; 0x3FF0+32=0x0010).
- sel=6 write during busy is dropped; v is not modified mid-operation.
- Reset mid-operation: immediate return to reset values; a pending write is lost and vram_wr is deasserted asynchronously.

Optional Feature:
- Macro: PPU_PALETTE_BYPASS_EN.
- Defined: a $2007 read with v[13:8]=6'h3F at the time of the strobe does not update cpu_dout at the strobe. Instead, cpu_dout<=vram_din in RCAP, i.e. unbuffered palette reads. rd_buf is also loaded with vram_din.
- Undefined: all reads are buffered, with no address special-casing.

Test Plan:
- Write $2006=0x21, $2006=0x08, $2007=0xAB, inc32=0 -> one vram_wr pulse with vram_addr=0x2108, vram_dout=0xAB; v=0x2109 afterwards.
- Preload mem[0x0000]=0x11, mem[0x0001]=0x22; set v=0x0000; three $2007 reads -> cpu_dout returns 0x00 (reset buffer), then 0x11, then 0x22.
- inc32=1, v=0x3FF0, $2007 write -> v=0x0010. With inc32=0 and v=0x3FFF, a write wraps v to 0x0000.
- $2006 write 0x3F, then $2002 read, then $2006 writes 0x12, 0x34 -> v=0x1234 (toggle cleared by the $2002 read).
- rnd_act=1 held for 10 cycles during a $2007 write -> vram_addr follows rnd_addr with no vram_wr for those 10 cycles. The write issues the cycle after rnd_act falls. cpu_busy is high throughout and a second strobe in that window is ignored.
- rst_n low during WAIT -> vram_wr stays 0, v=0, cpu_busy=0 immediately. With PPU_PALETTE_BYPASS_EN, mem[0x3F00]=0x0F and v=0x3F00, one read -> cpu_dout=0x0F.
